vip_flow_control_buffered_wrapper: RTL and testbench
====================================================

// Module: vip_flow_control_buffered_wrapper
// PURPOSE
//  Next-generation VIP flow-control wrapper between stream decoder, algorithm core and encoder.
//  Converts decoder ready/valid to stall/read and forwards only active video.
//  Buffers algorithm output in a parametrised FIFO, then converts to encoder ready/valid.
//  Sequences control packets in order with the video, supporting N pixels in parallel.
// PARAMETERS
//  BITS_PER_SYMBOL     8    bits per colour symbol
//  SYMBOLS_PER_BEAT    3    symbols per pixel
//  PIXELS_IN_PARALLEL  1    pixels per beat; DW = BITS_PER_SYMBOL*SYMBOLS_PER_BEAT*PIXELS_IN_PARALLEL
//  FIFO_DEPTH          4    output FIFO entries; power of 2, >=2
//  DEFAULT_WIDTH       640  reset value of encoder_width
//  DEFAULT_HEIGHT      480  reset value of encoder_height
// PORTS
//  clk                    in   1        clock
//  rst                    in   1        reset, asynchronous, active-high
//  din_valid              in   1        decoder beat valid
//  din_ready              out  1        = ~decoder_is_video | read
//  din_data               in   DW       decoder beat
//  decoder_is_video       in   1        current beat is active video
//  decoder_end_of_video   in   1        last beat of field
//  data_in                out  DW       = din_data
//  end_of_video_in        out  1        = decoder_end_of_video
//  read                   in   1        core consumes data_in
//  stall_in               out  1        = ~(din_valid & decoder_is_video)
//  data_out               in   DW       core output beat
//  end_of_video_out       in   1        core last-beat flag, stored with data_out
//  write                  in   1        core pushes data_out
//  stall_out              out  1        core must not write
//  width_out/height_out   in   16 each  core control values
//  interlaced_out         in   4        core control value
//  vip_ctrl_valid_out     in   1        core requests control packet
//  dout_valid             out  1        FIFO not empty
//  dout_ready             in   1        encoder accepts beat
//  dout_data              out  DW       FIFO head data
//  encoder_end_of_video   out  1        FIFO head eov flag & dout_valid
//  encoder_width/height   out  16 each  held control values
//  encoder_interlaced     out  4        held control value
//  encoder_vip_ctrl_send  out  1        one-cycle send strobe
//  encoder_vip_ctrl_busy  in   1        encoder control packet in progress
//  fifo_level             out  log2(FIFO_DEPTH)+1  current occupancy
//  overflow               out  1        sticky: write dropped while full
// BEHAVIOUR
//  Reset: FIFO empty, dout_valid=0, fifo_level=0, overflow=0, state IDLE, send=0.
//   Reset also sets width/height to DEFAULT_*, interlaced=0, stall_out=0.
//  Input path is purely combinational (equations above). No state on the input path.
//  FIFO: width DW+1 (data, eov), circular pointers wrap at FIFO_DEPTH. No bypass.
//   A write at cycle n gives dout_valid at n+1.
//   Pop when dout_valid & dout_ready.
//   Push accepted iff write & count<FIFO_DEPTH. Simultaneous push and pop with count<DEPTH leaves count unchanged.
//   write while full: beat dropped, overflow<=1 until reset.
//  stall_out = (count==FIFO_DEPTH) | (state==PEND).
//  Control FSM, 2 states:
//   IDLE: vip_ctrl_valid_out -> capture width/height/interlaced_out into held regs, go to PEND.
//   PEND: encoder_vip_ctrl_send = fifo empty & ~encoder_vip_ctrl_busy (combinational).
//    On send, go to IDLE.
//    If vip_ctrl_valid_out coincides with send, the current values are sent,
//     the new values are captured and the FSM stays in PEND.
//    vip_ctrl_valid_out while PEND without send: overwrite the held regs (latest wins).
//  Ordering: video written before the control request drains before send. Stalling while PEND blocks later video.
//  A write coincident with vip_ctrl_valid_out in IDLE is accepted and drains before send.
//  rst mid-frame: FIFO contents discarded, the pending control request is lost.
// TESTING
//  1. Reset, no writes -> dout_valid=0, encoder_width=640, encoder_height=480, send=0, stall_out=0.
//  2. FIFO_DEPTH=4, dout_ready=0, 5 writes -> stall_out=1 after the 4th.
//     The 5th write is dropped, overflow=1, fifo_level=4. Then dout_ready=1 -> 4 beats out in order.
//  3. Write 2 beats, then ctrl (1920,1080,0) with dout_ready=1 -> send only after the 2nd beat pops.
//     encoder_width=1920, and stall_out=1 until send.
//  4. Ctrl pending with busy=1 for 10 cycles -> no send. Busy falls -> send pulses exactly 1 cycle.
//  5. Ctrl A (720x576), then ctrl B (1280x720) before send -> a single send carrying 1280x720.
//  6. PIXELS_IN_PARALLEL=2, write with eov=1 -> dout_data is 48 bits and encoder_end_of_video=1 on that beat only.

Source files
------------

// File: rtl/vip_flow_control_buffered_wrapper_if.sv
// Bundle of every stream, control and status signal around the flow-control wrapper.
// The slave modport is the wrapper's view. The master modport is the surrounding
// decoder/core/encoder view.
interface vip_flow_control_buffered_wrapper_if #(
   parameter int DW = 24,
   parameter int LW = 3
);
   // decoder side
   logic          din_valid;
   logic          din_ready;
   logic [DW-1:0] din_data;
   logic          decoder_is_video;
   logic          decoder_end_of_video;
   // core input side
   logic [DW-1:0] data_in;
   logic          end_of_video_in;
   logic          read;
   logic          stall_in;
   // core output side
   logic [DW-1:0] data_out;
   logic          end_of_video_out;
   logic          write;
   logic          stall_out;
   logic [15:0]   width_out;
   logic [15:0]   height_out;
   logic [3:0]    interlaced_out;
   logic          vip_ctrl_valid_out;
   // encoder side
   logic          dout_valid;
   logic          dout_ready;
   logic [DW-1:0] dout_data;
   logic          encoder_end_of_video;
   logic [15:0]   encoder_width;
   logic [15:0]   encoder_height;
   logic [3:0]    encoder_interlaced;
   logic          encoder_vip_ctrl_send;
   logic          encoder_vip_ctrl_busy;
   // status
   logic [LW-1:0] fifo_level;
   logic          overflow;

   modport slave (
      input  din_valid, din_data, decoder_is_video, decoder_end_of_video,
      output din_ready,
      output data_in, end_of_video_in, stall_in,
      input  read,
      input  data_out, end_of_video_out, write,
      input  width_out, height_out, interlaced_out, vip_ctrl_valid_out,
      output stall_out,
      output dout_valid, dout_data, encoder_end_of_video,
      input  dout_ready,
      output encoder_width, encoder_height, encoder_interlaced, encoder_vip_ctrl_send,
      input  encoder_vip_ctrl_busy,
      output fifo_level, overflow
   );

   modport master (
      output din_valid, din_data, decoder_is_video, decoder_end_of_video,
      input  din_ready,
      input  data_in, end_of_video_in, stall_in,
      output read,
      output data_out, end_of_video_out, write,
      output width_out, height_out, interlaced_out, vip_ctrl_valid_out,
      input  stall_out,
      input  dout_valid, dout_data, encoder_end_of_video,
      output dout_ready,
      input  encoder_width, encoder_height, encoder_interlaced, encoder_vip_ctrl_send,
      output encoder_vip_ctrl_busy,
      input  fifo_level, overflow
   );
endinterface

// File: rtl/vip_flow_control_buffered_wrapper.sv
// Flow-control wrapper: combinational decoder->core adaptation, buffered core->encoder
// path, and a two-state sequencer that keeps control packets ordered behind video.
module vip_flow_control_buffered_wrapper #(
   parameter int          BITS_PER_SYMBOL    = 8,
   parameter int          SYMBOLS_PER_BEAT   = 3,
   parameter int          PIXELS_IN_PARALLEL = 1,
   parameter int          FIFO_DEPTH         = 4,
   parameter logic [15:0] DEFAULT_WIDTH      = 16'd640,
   parameter logic [15:0] DEFAULT_HEIGHT     = 16'd480
) (
   input logic clk,
   input logic rst,
   vip_flow_control_buffered_wrapper_if.slave bus
);
   localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT * PIXELS_IN_PARALLEL;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

   typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

   // Input path: pure wiring. The core only sees stall_in low on valid active video.
   assign bus.data_in         = bus.din_data;
   assign bus.end_of_video_in = bus.decoder_end_of_video;
   assign bus.din_ready       = ~bus.decoder_is_video | bus.read;
   assign bus.stall_in        = ~(bus.din_valid & bus.decoder_is_video);

   // Output FIFO. Each entry holds {eov, data}.
   logic [DW:0]    mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_reg;
   logic [AW-1:0]  rd_ptr_reg;
   logic [LW-1:0]  count_reg;
   logic           overflow_reg;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   logic [DW:0]    head;

   assign full  = (count_reg == FULL_LEVEL);
   assign empty = (count_reg == '0);
   // A full FIFO rejects the write even when a pop happens in the same cycle.
   assign push  = bus.write & ~full;
   assign pop   = ~empty & bus.dout_ready;
   assign head  = mem[rd_ptr_reg];

   // Pointer, occupancy and sticky overflow bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, pop};
         if (bus.write & full) overflow_reg <= 1'b1;
      end
   end

   // Storage array; contents need no reset because the occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= {bus.end_of_video_out, bus.data_out};
   end

   assign bus.dout_valid           = ~empty;
   assign bus.dout_data            = head[DW-1:0];
   assign bus.encoder_end_of_video = head[DW] & ~empty;
   assign bus.fifo_level           = count_reg;
   assign bus.overflow             = overflow_reg;

   // Control sequencer.
   state_t      state_reg;
   state_t      state_next;
   logic        send;
   logic [15:0] width_reg;
   logic [15:0] height_reg;
   logic [3:0]  interlaced_reg;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next state: a new request always leaves us pending; a send without one returns to idle.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.vip_ctrl_valid_out) state_next = PEND;
         PEND:    if (send & ~bus.vip_ctrl_valid_out) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs: send once the queued video has drained and the encoder is free.
   always_comb begin
      send = 1'b0;
      bus.stall_out = full;
      if (state_reg == PEND) begin
         send = empty & ~bus.encoder_vip_ctrl_busy;
         bus.stall_out = 1'b1;
      end
   end

   assign bus.encoder_vip_ctrl_send = send;

   // Held control values. The latest request wins; a send in the same cycle still
   // carries the previously held values because the capture lands on the next edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         width_reg      <= DEFAULT_WIDTH;
         height_reg     <= DEFAULT_HEIGHT;
         interlaced_reg <= 4'd0;
      end else if (bus.vip_ctrl_valid_out) begin
         width_reg      <= bus.width_out;
         height_reg     <= bus.height_out;
         interlaced_reg <= bus.interlaced_out;
      end
   end

   assign bus.encoder_width      = width_reg;
   assign bus.encoder_height     = height_reg;
   assign bus.encoder_interlaced = interlaced_reg;
endmodule

// File: tb/tb_vip_flow_control_buffered_wrapper.sv
// Bench for the flow-control wrapper: input-path vector table, directed corner
// sequences, and a randomized run against a queue-based model.
module tb_vip_flow_control_buffered_wrapper;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   vip_flow_control_buffered_wrapper_if #(.DW(24), .LW(3)) bus ();
   vip_flow_control_buffered_wrapper_if #(.DW(48), .LW(3)) bus2 ();

   vip_flow_control_buffered_wrapper #(.PIXELS_IN_PARALLEL(1), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .bus(bus));
   vip_flow_control_buffered_wrapper #(.PIXELS_IN_PARALLEL(2), .FIFO_DEPTH(4)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2));

   typedef struct {
      logic        dv;
      logic        vid;
      logic        rd;
      logic        eov;
      logic [23:0] data;
      logic        exp_ready;
      logic        exp_stall;
   } vec_t;

   typedef struct {
      logic [23:0] d;
      logic        e;
   } beat_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.din_valid = 0; bus.din_data = '0; bus.decoder_is_video = 0;
      bus.decoder_end_of_video = 0; bus.read = 0; bus.data_out = '0;
      bus.end_of_video_out = 0; bus.write = 0; bus.width_out = '0; bus.height_out = '0;
      bus.interlaced_out = '0; bus.vip_ctrl_valid_out = 0; bus.dout_ready = 0;
      bus.encoder_vip_ctrl_busy = 0;
      bus2.din_valid = 0; bus2.din_data = '0; bus2.decoder_is_video = 0;
      bus2.decoder_end_of_video = 0; bus2.read = 0; bus2.data_out = '0;
      bus2.end_of_video_out = 0; bus2.write = 0; bus2.width_out = '0; bus2.height_out = '0;
      bus2.interlaced_out = '0; bus2.vip_ctrl_valid_out = 0; bus2.dout_ready = 0;
      bus2.encoder_vip_ctrl_busy = 0;
   endtask

   // Asynchronous reset: outputs must clear before any clock edge arrives.
   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      #2;
      check("async_rst_level", bus.fifo_level, 0);
      check("async_rst_valid", bus.dout_valid, 0);
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      vec_t  vecs[6];
      beat_t q[$];
      beat_t b;
      int    sends;
      logic  pend, ovf, exp_send, push_ok;
      logic [15:0] mw, mh;
      logic [3:0]  mi;

      clear_inputs();
      vecs[0] = '{1, 1, 1, 0, 24'h123456, 1, 0};
      vecs[1] = '{1, 1, 0, 1, 24'hABCDEF, 0, 0};
      vecs[2] = '{0, 1, 0, 0, 24'h000001, 0, 1};
      vecs[3] = '{0, 0, 0, 1, 24'hFFFFFF, 1, 1};
      vecs[4] = '{1, 0, 0, 0, 24'h5A5A5A, 1, 1};
      vecs[5] = '{0, 1, 1, 1, 24'h0F0F0F, 1, 1};

      repeat (2) tick();
      rst = 1'b0;
      tick();

      // 1. reset state
      check("rst_dout_valid", bus.dout_valid, 0);
      check("rst_width", bus.encoder_width, 640);
      check("rst_height", bus.encoder_height, 480);
      check("rst_interlaced", bus.encoder_interlaced, 0);
      check("rst_send", bus.encoder_vip_ctrl_send, 0);
      check("rst_stall_out", bus.stall_out, 0);
      check("rst_level", bus.fifo_level, 0);
      check("rst_overflow", bus.overflow, 0);
      $display("reset state checked");

      // Input path vectors
      for (int i = 0; i < 6; i++) begin
         bus.din_valid = vecs[i].dv; bus.decoder_is_video = vecs[i].vid;
         bus.read = vecs[i].rd; bus.decoder_end_of_video = vecs[i].eov;
         bus.din_data = vecs[i].data;
         #1;
         check("vec_din_ready", bus.din_ready, vecs[i].exp_ready);
         check("vec_stall_in", bus.stall_in, vecs[i].exp_stall);
         check("vec_data_in", bus.data_in, vecs[i].data);
         check("vec_eov_in", bus.end_of_video_in, vecs[i].eov);
         $display("vector %0d dv=%0b vid=%0b rd=%0b ready=%0b stall_in=%0b", i,
                  vecs[i].dv, vecs[i].vid, vecs[i].rd, bus.din_ready, bus.stall_in);
         tick();
      end
      clear_inputs();

      // 2. fill to full, overflow on 5th write, drain in order
      do_reset();
      for (int i = 0; i < 5; i++) begin
         bus.write = 1; bus.data_out = 24'h100 + 24'(i);
         #1;
         if (i == 4) begin
            check("full_stall_out", bus.stall_out, 1);
            check("full_no_ovf_yet", bus.overflow, 0);
         end
         tick();
      end
      bus.write = 0;
      #1;
      check("ovf_level", bus.fifo_level, 4);
      check("ovf_sticky", bus.overflow, 1);
      bus.dout_ready = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("drain_valid", bus.dout_valid, 1);
         check("drain_data", bus.dout_data, 24'h100 + 24'(i));
         $display("drain beat %0d data=%0h", i, bus.dout_data);
         tick();
      end
      check("drain_empty", bus.dout_valid, 0);
      check("ovf_still_set", bus.overflow, 1);

      // 3. control waits behind two video beats
      do_reset();
      bus.write = 1; bus.data_out = 24'hAAA001; tick();
      bus.data_out = 24'hAAA002; tick();
      bus.write = 0; bus.dout_ready = 1;
      bus.vip_ctrl_valid_out = 1; bus.width_out = 1920; bus.height_out = 1080;
      bus.interlaced_out = 0;
      #1;
      check("c3_no_send_idle", bus.encoder_vip_ctrl_send, 0);
      check("c3_head0", bus.dout_data, 24'hAAA001);
      tick();
      bus.vip_ctrl_valid_out = 0;
      #1;
      check("c3_stall_pend", bus.stall_out, 1);
      check("c3_no_send_data", bus.encoder_vip_ctrl_send, 0);
      check("c3_width", bus.encoder_width, 1920);
      check("c3_head1", bus.dout_data, 24'hAAA002);
      tick();
      check("c3_send", bus.encoder_vip_ctrl_send, 1);
      check("c3_height", bus.encoder_height, 1080);
      check("c3_stall_at_send", bus.stall_out, 1);
      tick();
      check("c3_send_done", bus.encoder_vip_ctrl_send, 0);
      check("c3_stall_clear", bus.stall_out, 0);
      $display("control after video sent width=%0d", bus.encoder_width);

      // 4. busy holds off the send
      do_reset();
      bus.encoder_vip_ctrl_busy = 1;
      bus.vip_ctrl_valid_out = 1; bus.width_out = 100; bus.height_out = 200;
      bus.interlaced_out = 4'h3;
      tick();
      bus.vip_ctrl_valid_out = 0;
      sends = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         sends += int'(bus.encoder_vip_ctrl_send);
         tick();
      end
      check("busy_no_send", sends, 0);
      bus.encoder_vip_ctrl_busy = 0;
      #1;
      check("busy_release_send", bus.encoder_vip_ctrl_send, 1);
      check("busy_interlaced", bus.encoder_interlaced, 3);
      tick();
      check("busy_send_one_cycle", bus.encoder_vip_ctrl_send, 0);
      $display("busy release gave single send");

      // 5. latest control request wins
      do_reset();
      bus.encoder_vip_ctrl_busy = 1;
      bus.vip_ctrl_valid_out = 1; bus.width_out = 720; bus.height_out = 576;
      tick();
      bus.width_out = 1280; bus.height_out = 720;
      tick();
      bus.vip_ctrl_valid_out = 0; bus.encoder_vip_ctrl_busy = 0;
      #1;
      check("latest_send", bus.encoder_vip_ctrl_send, 1);
      check("latest_width", bus.encoder_width, 1280);
      check("latest_height", bus.encoder_height, 720);
      tick();
      sends = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         sends += int'(bus.encoder_vip_ctrl_send);
         tick();
      end
      check("latest_single_send", sends, 0);
      $display("overwritten control sent 1280x720");

      // 6. two pixels per beat, eov marks only its own beat
      do_reset();
      bus2.write = 1; bus2.data_out = 48'hFEDCBA987654; bus2.end_of_video_out = 1;
      tick();
      bus2.data_out = 48'h123456789ABC; bus2.end_of_video_out = 0;
      tick();
      bus2.write = 0; bus2.dout_ready = 1;
      #1;
      check("pip2_data0", bus2.dout_data, 48'hFEDCBA987654);
      check("pip2_eov0", bus2.encoder_end_of_video, 1);
      tick();
      check("pip2_data1", bus2.dout_data, 48'h123456789ABC);
      check("pip2_eov1", bus2.encoder_end_of_video, 0);
      tick();
      check("pip2_empty_eov", bus2.encoder_end_of_video, 0);
      $display("wide beat eov checked");

      // Randomized run against a queue model
      do_reset();
      q.delete();
      pend = 0; ovf = 0; mw = 640; mh = 480; mi = 0;
      for (int c = 0; c < 600; c++) begin
         bus.write = ($urandom_range(0, 2) != 0);
         bus.data_out = 24'($urandom);
         bus.end_of_video_out = 1'($urandom);
         bus.dout_ready = ($urandom_range(0, 2) == 0);
         bus.vip_ctrl_valid_out = ($urandom_range(0, 11) == 0);
         bus.width_out = 16'($urandom);
         bus.height_out = 16'($urandom);
         bus.interlaced_out = 4'($urandom);
         bus.encoder_vip_ctrl_busy = ($urandom_range(0, 3) == 0);
         #1;
         exp_send = pend && q.size() == 0 && !bus.encoder_vip_ctrl_busy;
         check("rnd_valid", bus.dout_valid, q.size() != 0);
         check("rnd_level", bus.fifo_level, q.size());
         check("rnd_stall_out", bus.stall_out, (q.size() == 4) || pend);
         check("rnd_send", bus.encoder_vip_ctrl_send, exp_send);
         check("rnd_width", bus.encoder_width, mw);
         check("rnd_height", bus.encoder_height, mh);
         check("rnd_interlaced", bus.encoder_interlaced, mi);
         check("rnd_overflow", bus.overflow, ovf);
         if (q.size() != 0) begin
            check("rnd_data", bus.dout_data, q[0].d);
            check("rnd_eov", bus.encoder_end_of_video, q[0].e);
         end else begin
            check("rnd_eov_empty", bus.encoder_end_of_video, 0);
         end
         // model update
         push_ok = bus.write && q.size() < 4;
         if (bus.write && q.size() == 4) ovf = 1;
         if (q.size() != 0 && bus.dout_ready) void'(q.pop_front());
         if (push_ok) begin
            b.d = bus.data_out; b.e = bus.end_of_video_out;
            q.push_back(b);
         end
         if (exp_send) pend = bus.vip_ctrl_valid_out;
         else if (bus.vip_ctrl_valid_out) pend = 1;
         if (bus.vip_ctrl_valid_out) begin
            mw = bus.width_out; mh = bus.height_out; mi = bus.interlaced_out;
         end
         tick();
      end
      $display("random run done, %0d beats left in model", q.size());

      // Reset mid-frame: queued video and the pending request are lost
      clear_inputs();
      bus.write = 1; bus.data_out = 24'h777777; tick();
      bus.write = 0;
      bus.vip_ctrl_valid_out = 1; bus.width_out = 99; tick();
      do_reset();
      sends = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         sends += int'(bus.encoder_vip_ctrl_send);
         tick();
      end
      check("midrst_no_send", sends, 0);
      check("midrst_valid", bus.dout_valid, 0);
      check("midrst_stall", bus.stall_out, 0);
      check("midrst_width", bus.encoder_width, 640);
      $display("mid-frame reset checked");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
